// File: rtl/data_mem_pkg.sv
// Shared codes for the data memory: access sizes, FSM states, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package data_mem_pkg;

    // Access size codes; the core's store_sel drives the same values.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_R = 2'd3
    } size_e;

    // Access sequencer states; DM_WAIT only exists in wait-state builds.
    typedef enum logic {
        DM_IDLE = 1'b0,
        DM_WAIT = 1'b1
    } dm_state_e;

    // Byte-lane write enables for an aligned access of the given size.
    function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] we;
        we = 4'b0000;
        case (size)
            SIZE_B:  we = 4'b0001 << ofs;
            SIZE_H:  we = ofs[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    // Replicate right-aligned write data across lanes so the enables pick it out.
    function automatic logic [31:0] lane_dat(input logic [1:0] size, input logic [31:0] din);
        logic [31:0] dat;
        dat = din;
        case (size)
            SIZE_B:  dat = {4{din[7:0]}};
            SIZE_H:  dat = {2{din[15:0]}};
            default: dat = din;
        endcase
        return dat;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Core-to-data-memory access bus.
// Latency: n/a (signal bundle).
// Backpressure: memory stalls the core with mem_busy; request fields held while busy.
interface data_mem_if;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_ain;
    logic [1:0]  mem_size;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_busy;
    logic        mem_fault;

    modport master (
        output mem_req, mem_rw, mem_ain, mem_size, mem_din,
        input  mem_dout, mem_busy, mem_fault
    );

    modport slave (
        input  mem_req, mem_rw, mem_ain, mem_size, mem_din,
        output mem_dout, mem_busy, mem_fault
    );
endinterface

// File: rtl/data_mem_array.sv
// dmem_array: byte-lane-enabled single-port synchronous RAM, 32-bit words.
// Latency: write lands at the clock edge; read data registered, valid after the edge.
// Backpressure: none; accepts one operation per cycle.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdat,
    input  logic          rd_en,
    output logic [31:0]   rdat
);

    logic [31:0] mem [DEPTH_WORDS];

    // Storage is never reset: contents survive reset by design.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdat[b*8 +: 8];
            end
        end
    end

    // Read register only loads on a committed read, otherwise holds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdat <= 32'd0;
        end else if (rd_en) begin
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem.sv
// Data memory with size/alignment/range checking; wait states when DMEM_WAIT_EN is defined.
// Latency: commit WAIT_CYCLES+1 cycles after request (1 without DMEM_WAIT_EN); read data the cycle after commit.
// Backpressure: mem_busy stalls the core; it holds request fields stable until mem_busy drops.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    data_mem_if.slave  bus
);

    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    logic          commit;
    logic          busy_c;
    logic          fault_c;
    logic [3:0]    ram_we;
    logic          ram_rd;
    logic [AW-1:0] word_idx;
    logic [31:0]   wdat;

    // Reject reserved size, misaligned half/word, and anything past the end of storage.
    always_comb begin
        fault_c = 1'b0;
        if (bus.mem_size == SIZE_R) begin
            fault_c = 1'b1;
        end
        if (bus.mem_size == SIZE_H && bus.mem_ain[0]) begin
            fault_c = 1'b1;
        end
        if (bus.mem_size == SIZE_W && bus.mem_ain[1:0] != 2'b00) begin
            fault_c = 1'b1;
        end
        if ({1'b0, bus.mem_ain} >= LIMIT) begin
            fault_c = 1'b1;
        end
    end

`ifdef DMEM_WAIT_EN
    // Counter only needs to hold WAIT_CYCLES-1.
    localparam int          CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    dm_state_e     state, next_state;
    logic [CW-1:0] cnt, next_cnt;

    // Sequencer state and stall counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= DM_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next state, stall and commit decode; WAIT_CYCLES=0 collapses to a single-cycle commit.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        busy_c     = 1'b0;
        commit     = 1'b0;
        case (state)
            DM_IDLE: begin
                if (bus.mem_req) begin
                    if (WAIT_CYCLES > 0) begin
                        busy_c     = 1'b1;
                        next_state = DM_WAIT;
                        next_cnt   = CNT_LOAD;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt != '0) begin
                    busy_c   = 1'b1;
                    next_cnt = cnt - CW'(1);
                end else begin
                    commit     = 1'b1;
                    next_state = DM_IDLE;
                end
            end
            default: begin
                next_state = DM_IDLE;
                next_cnt   = '0;
            end
        endcase
    end
`else
    // Zero-wait build: every request cycle is its commit cycle.
    logic unused_wait_cycles;
    assign unused_wait_cycles = ^WAIT_CYCLES;
    assign busy_c = 1'b0;
    assign commit = bus.mem_req;
`endif

    // Reset forces the stall low even if a request is presented.
    assign bus.mem_busy = busy_c & reset;

    assign word_idx = bus.mem_ain[AW+1:2];
    assign wdat     = lane_dat(bus.mem_size, bus.mem_din);
    // The RAM has no reset, so an edge during reset must not write.
    assign ram_we   = (commit && bus.mem_rw && !fault_c && reset)
                      ? lane_we(bus.mem_size, bus.mem_ain[1:0]) : 4'b0000;
    assign ram_rd   = commit && !bus.mem_rw && !fault_c;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .addr  (word_idx),
        .wdat  (wdat),
        .rd_en (ram_rd),
        .rdat  (bus.mem_dout)
    );

    // Fault pulse for the cycle following a rejected commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mem_fault <= 1'b0;
        end else begin
            bus.mem_fault <= commit && fault_c;
        end
    end

endmodule
